// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MDU_FASTMUL_EN replaces the iterative multiply with a single-cycle N x N multiplier.
module mdu_seq #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   rs_val,
    input  logic [N-1:0]   rt_val,
    input  logic           cancel,
    output logic           busy,
    output logic           hilo_wr,
    output logic           mdiv,
    output logic [2*N-1:0] hilo_data,
    output logic           div_by_zero
);

    localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        WRITE
    } state_t;

    state_t state, state_nx;

    logic           is_div_q;
    logic           sa_q;
    logic           sb_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;

    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_nx;
    logic [N:0]     div_sh;
    logic [N:0]     div_trial;
    logic [2*N-1:0] div_nx;

    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [2*N-1:0] fix_data;
    logic           fix_dz;

`ifdef MDU_FASTMUL_EN
    logic [2*N-1:0] fast_prod;
`endif

    // Operand conditioning: signed ops work on magnitudes, signs re-applied in FIX.
    always_comb begin
        accept = (state == IDLE) && start && !cancel;
        a_neg  = !op[0] && rs_val[N-1];
        b_neg  = !op[0] && rt_val[N-1];
        a_mag  = a_neg ? -rs_val : rs_val;
        b_mag  = b_neg ? -rt_val : rt_val;
    end

`ifdef MDU_FASTMUL_EN
    always_comb begin
        fast_prod = {{N{1'b0}}, a_mag} * {{N{1'b0}}, b_mag};
    end
`endif

    // acc holds {partial HI, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_nx    = {mul_sum, acc[N-1:1]};
        div_sh    = {acc[2*N-1:N], acc[N-1]};
        div_trial = div_sh - {1'b0, b_q};
        div_nx    = div_trial[N] ? {div_sh[N-1:0], acc[N-2:0], 1'b0}
                                 : {div_trial[N-1:0], acc[N-2:0], 1'b1};
    end

    always_comb begin
        quo      = acc[N-1:0];
        rem      = acc[2*N-1:N];
        fix_data = '0;
        fix_dz   = 1'b0;
        if (!is_div_q) begin
            fix_data = (sa_q ^ sb_q) ? -acc : acc;
        end else if (b_q == '0) begin
            fix_data = {a_q, {N{1'b1}}};
            fix_dz   = 1'b1;
        end else begin
            fix_data = {(sa_q ? -rem : rem), ((sa_q ^ sb_q) ? -quo : quo)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MDU_FASTMUL_EN
                    state_nx = op[1] ? CALC : FIX;
`else
                    state_nx = CALC;
`endif
                end
            end
            CALC: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = cancel ? IDLE : WRITE;
            end
            WRITE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div_q    <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            cnt         <= '0;
            hilo_wr     <= 1'b0;
            hilo_data   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // The write strobe trails WRITE by one cycle so data is already stable.
            hilo_wr <= (state == WRITE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div_q <= op[1];
                        sa_q     <= a_neg;
                        sb_q     <= b_neg;
                        a_q      <= rs_val;
                        b_q      <= b_mag;
                        cnt      <= '0;
`ifdef MDU_FASTMUL_EN
                        acc      <= op[1] ? {{N{1'b0}}, a_mag} : fast_prod;
`else
                        acc      <= {{N{1'b0}}, a_mag};
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div_q ? div_nx : mul_nx;
                end
                FIX: begin
                    if (!cancel) begin
                        hilo_data   <= fix_data;
                        div_by_zero <= fix_dz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign mdiv = hilo_wr;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: results, latency, cancel, back-to-back issue, async reset.
module tb_mdu_seq;

    localparam int unsigned N = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   rs_val;
    logic [N-1:0]   rt_val;
    logic           cancel;
    logic           busy;
    logic           hilo_wr;
    logic           mdiv;
    logic [2*N-1:0] hilo_data;
    logic           div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .cancel     (cancel),
        .busy       (busy),
        .hilo_wr    (hilo_wr),
        .mdiv       (mdiv),
        .hilo_data  (hilo_data),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int op_latency(input logic [1:0] o);
        int lat;
        lat = N + 2;
`ifdef MDU_FASTMUL_EN
        if (!o[1]) lat = 2;
`endif
        return lat;
    endfunction

    // Issues one op on the next edge, scrambles operands afterwards, waits (bounded) for the write.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input logic edz, input string tag,
                          input bit cancel_in_write);
        int lat;
        int k;
        bit seen;
        lat    = op_latency(o);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < lat + 8) begin
            @(posedge clk); #1;
            k++;
            cancel = 1'b0;
            if (hilo_wr) begin
                seen = 1'b1;
            end else if (cancel_in_write && k == lat - 1) begin
                cancel = 1'b1;
            end
        end
        cancel = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_data"}, hilo_data, exp);
        check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        check({tag, "_mdiv"}, 64'(mdiv), 64'(hilo_wr));
        @(posedge clk); #1;
        check({tag, "_pulse1"}, 64'(hilo_wr), 64'd0);
    endtask

    initial begin
        int lat;
        int per;
        int npulse;
        int last;

        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr", 64'(hilo_wr), 64'd0);
        check("rst_mdiv", 64'(mdiv), 64'd0);
        check("rst_data", hilo_data, 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, "multu_max", 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "mult_neg", 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_neg", 1'b0);
        run_op(2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 1'b1, "divu_zero", 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "div_ovf", 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "divu_100_7", 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, "div_pos_neg", 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 1'b1, "div_zero", 1'b0);
        run_op(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, 64'h00000000_00000014, 1'b0, "mult_cw", 1'b1);

        // Cancel mid-CALC: start at edge 0, cancel sampled at edge 10.
        op     = 2'b10;
        rs_val = 32'd100;
        rt_val = 32'd3;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_wr", 64'(hilo_wr), 64'd0);
        check("cancel_data", hilo_data, 64'h00000000_00000014);
        @(posedge clk); #1;
        check("cancel_wr2", 64'(hilo_wr), 64'd0);
        run_op(2'b11, 32'd1000, 32'd10, 64'h00000000_00000064, 1'b0, "after_cancel", 1'b0);

        // Cancel together with start in IDLE drops the request.
        op     = 2'b01;
        rs_val = 32'd9;
        rt_val = 32'd9;
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("cs_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("cs_wr", 64'(hilo_wr), 64'd0);
        check("cs_data", hilo_data, 64'h00000000_00000064);

        // start held for 40 cycles: one write per lat+1 cycles.
        lat    = op_latency(2'b01);
        per    = lat + 1;
        npulse = 0;
        last   = 0;
        op     = 2'b01;
        rs_val = 32'd3;
        rt_val = 32'd5;
        start  = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (e == 39) start = 1'b0;
            if (hilo_wr) begin
                if (npulse == 0) check("held_first", 64'(e), 64'(lat));
                else check("held_spacing", 64'(e - last), 64'(per));
                check("held_data", hilo_data, 64'd15);
                last = e;
                npulse++;
            end
        end
        check("held_count", 64'(npulse), 64'((40 + per - 1) / per));

        // Asynchronous reset between edges during CALC.
        op     = 2'b10;
        rs_val = 32'd100;
        rt_val = 32'hFFFFFFFD;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wr", 64'(hilo_wr), 64'd0);
        check("arst_mdiv", 64'(mdiv), 64'd0);
        check("arst_data", hilo_data, 64'd0);
        check("arst_dz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_op(2'b10, 32'd100, 32'hFFFFFFFD, 64'h00000001_FFFFFFDF, 1'b0, "after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
